telemetry_pkt: RTL and testbench

//  Parametrised periodic telemetry packetiser. Every PERIOD clocks it snapshots NUM_CH

---
 rtl/telemetry_pkt.sv | 188 ++++++++++++++++++
 tb/tb_telemetry_pkt.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_pkt.sv
// Periodic telemetry packetiser: every period it snapshots NUM_CH channels and streams
// SYNC0, SYNC1, {HI, LO} per channel and a two's-complement checksum over a byte handshake.
module telemetry_pkt #(
  parameter int         NUM_CH   = 3,
  parameter int         CH_W     = 12,
  parameter int         PERIOD_W = 20,
  parameter logic [7:0] SYNC0    = 8'hAA,
  parameter logic [7:0] SYNC1    = 8'h55
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic                   tx_done,
  input  logic                   overrun_clr,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   overrun
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC0 = 3'd1,
    ST_SYNC1 = 3'd2,
    ST_HI    = 3'd3,
    ST_LO    = 3'd4,
    ST_CKSUM = 3'd5
  } state_t;

  function automatic logic [7:0] cksum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  // Negated running sum so that payload plus checksum sums to zero mod 256.
  function automatic logic [7:0] cksum_final(input logic [7:0] acc);
    return 8'd0 - acc;
  endfunction

  state_t                 state_r;
  logic [PERIOD_W-1:0]    cnt_r;
  logic [NUM_CH*CH_W-1:0] snap_r;
  logic [IDX_W-1:0]       idx_r;
  logic [7:0]             acc_r;
  logic [7:0]             tx_data_r;
  logic                   done_q_r;
  logic                   load_r;
  logic                   trmt_r;
  logic                   busy_r;
  logic                   overrun_r;

  logic                   wrap_s;
  logic                   done_rise_s;
  logic                   adv_s;
  logic [15:0]            ch16_s;
  logic [7:0]             byte_s;
  logic                   payload_s;

  // Period wrap and handshake edge qualification
  always_comb begin
    wrap_s = 1'b0;
    if (period <= PERIOD_W'(1)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = (cnt_r >= (period - PERIOD_W'(1)));
    end
    done_rise_s = tx_done & ~done_q_r;
    // A completion seen while the byte is still being presented is not ours.
    adv_s = done_rise_s & ~trmt_r & ~load_r & (state_r != ST_IDLE);
  end

  // Selects the byte for the state just entered
  always_comb begin
    ch16_s             = 16'd0;
    ch16_s[CH_W-1:0]   = snap_r[int'(idx_r) * CH_W +: CH_W];
    byte_s             = 8'd0;
    payload_s          = 1'b0;
    case (state_r)
      ST_SYNC1: begin
        byte_s = SYNC1;
      end
      ST_HI: begin
        byte_s    = ch16_s[15:8];
        payload_s = 1'b1;
      end
      ST_LO: begin
        byte_s    = ch16_s[7:0];
        payload_s = 1'b1;
      end
      ST_CKSUM: begin
        byte_s = cksum_final(acc_r);
      end
      default: begin
        byte_s = SYNC0;
      end
    endcase
  end

  // Free-running period counter, tx_done edge register and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {PERIOD_W{1'b0}};
      done_q_r  <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      done_q_r <= tx_done;
      if (wrap_s) begin
        cnt_r <= {PERIOD_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + PERIOD_W'(1);
      end
      if (wrap_s && busy_r) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  // Packet FSM: launch, one-cycle gap after each completion, then present next byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      snap_r    <= {(NUM_CH*CH_W){1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      acc_r     <= 8'd0;
      tx_data_r <= 8'd0;
      load_r    <= 1'b0;
      trmt_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      trmt_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (wrap_s && en) begin
            snap_r    <= ch_data;
            idx_r     <= {IDX_W{1'b0}};
            acc_r     <= 8'd0;
            busy_r    <= 1'b1;
            trmt_r    <= 1'b1;
            tx_data_r <= SYNC0;
            state_r   <= ST_SYNC0;
          end
        end
        default: begin
          if (load_r) begin
            load_r    <= 1'b0;
            trmt_r    <= 1'b1;
            tx_data_r <= byte_s;
            if (payload_s) begin
              acc_r <= cksum_add(acc_r, byte_s);
            end
          end else if (adv_s) begin
            load_r <= 1'b1;
            case (state_r)
              ST_SYNC0: state_r <= ST_SYNC1;
              ST_SYNC1: state_r <= ST_HI;
              ST_HI:    state_r <= ST_LO;
              ST_LO: begin
                if (idx_r == LAST_IDX) begin
                  state_r <= ST_CKSUM;
                end else begin
                  idx_r   <= idx_r + IDX_W'(1);
                  state_r <= ST_HI;
                end
              end
              default: begin
                load_r  <= 1'b0;
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign trmt    = trmt_r;
  assign tx_data = tx_data_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_telemetry_pkt.sv
// Scoreboard bench for telemetry_pkt: a 3x12-bit instance with an automatic UART responder
// and a 1x16-bit instance driven by hand.
module tb_telemetry_pkt;

  localparam int PW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, en, tx_done, tx_done_auto, tx_done_man, overrun_clr;
  logic          trmt, busy, overrun;
  logic [PW-1:0] period;
  logic [35:0]   ch_data;
  logic [7:0]    tx_data;

  logic          en1, tx_done1, overrun_clr1, trmt1, busy1, overrun1;
  logic [PW-1:0] period1;
  logic [15:0]   ch_data1;
  logic [7:0]    tx_data1;

  logic          resp_on;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            trmt_cnt = 0;
  int            cyc      = 0;
  int            last_cyc = 0;
  int            gap      = 0;
  logic [7:0]    last_exp = 8'd0;
  logic [7:0]    exp_q[$];
  logic [7:0]    exp_q1[$];

  assign tx_done = resp_on ? tx_done_auto : tx_done_man;

  telemetry_pkt #(.NUM_CH(3), .CH_W(12), .PERIOD_W(PW), .SYNC0(8'hAA), .SYNC1(8'h55)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .period(period), .ch_data(ch_data),
    .tx_done(tx_done), .overrun_clr(overrun_clr), .trmt(trmt), .tx_data(tx_data),
    .busy(busy), .overrun(overrun)
  );

  telemetry_pkt #(.NUM_CH(1), .CH_W(16), .PERIOD_W(PW), .SYNC0(8'hAA), .SYNC1(8'h55)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .period(period1), .ch_data(ch_data1),
    .tx_done(tx_done1), .overrun_clr(overrun_clr1), .trmt(trmt1), .tx_data(tx_data1),
    .busy(busy1), .overrun(overrun1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Expected frame: sync bytes, big-endian channels, negated payload sum.
  function automatic void push_frame(input bit to_one, input int nch,
                                     input logic [15:0] c0, input logic [15:0] c1,
                                     input logic [15:0] c2);
    logic [15:0] v [3];
    logic [7:0]  sum;
    logic [7:0]  b[$];
    v[0] = c0; v[1] = c1; v[2] = c2;
    sum  = 8'd0;
    b.push_back(8'hAA);
    b.push_back(8'h55);
    for (int k = 0; k < nch; k++) begin
      b.push_back(v[k][15:8]);
      b.push_back(v[k][7:0]);
      sum = sum + v[k][15:8] + v[k][7:0];
    end
    b.push_back(8'd0 - sum);
    foreach (b[i]) begin
      if (to_one) exp_q1.push_back(b[i]);
      else        exp_q.push_back(b[i]);
    end
  endfunction

  task automatic wait_cnt(input int target, input int budget, input string tag);
    int n = 0;
    while (trmt_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk_eq(tag, 32'(trmt_cnt), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk_eq(tag, 32'(busy), 32'd0);
  endtask

  // Byte monitor: pops the scoreboard on every strobe, checks hold between strobes
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_exp = 8'd0;
      end else if (trmt) begin
        trmt_cnt++;
        gap      = cyc - last_cyc;
        last_cyc = cyc;
        chk_eq("busy_at_trmt", 32'(busy), 32'd1);
        chk_eq("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_eq("tx_byte", 32'(tx_data), 32'(e));
          last_exp = e;
        end
      end else begin
        chk_eq("tx_hold", 32'(tx_data), 32'(last_exp));
      end
    end
  end

  // UART model: one-cycle tx_done pulse 10 clocks after each strobe
  initial begin
    int wait_left = 0;
    int hold_left = 0;
    tx_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_on) begin
        if (trmt) begin
          wait_left = 10;
        end else if (wait_left > 0) begin
          wait_left--;
          if (wait_left == 0) hold_left = 1;
        end
        tx_done_auto = (hold_left > 0);
        if (hold_left > 0) hold_left--;
      end else begin
        wait_left    = 0;
        hold_left    = 0;
        tx_done_auto = 1'b0;
      end
    end
  end

  initial begin
    int         base;
    int         n;
    logic [7:0] e;
    rst_n = 1'b0; en = 1'b0; en1 = 1'b0; tx_done_man = 1'b0; tx_done1 = 1'b0;
    overrun_clr = 1'b0; overrun_clr1 = 1'b0; resp_on = 1'b0;
    period  = PW'(5000);
    period1 = PW'(0);
    ch_data  = {12'h7FF, 12'h123, 12'hABC};
    ch_data1 = 16'hFFFF;
    repeat (3) tick();
    chk_eq("rst_trmt", 32'(trmt), 32'd0);
    chk_eq("rst_tx_data", 32'(tx_data), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_overrun", 32'(overrun), 32'd0);
    chk_eq("rst_trmt1", 32'(trmt1), 32'd0);
    chk_eq("rst_tx_data1", 32'(tx_data1), 32'd0);
    chk_eq("rst_busy1", 32'(busy1), 32'd0);
    chk_eq("rst_overrun1", 32'(overrun1), 32'd0);
    rst_n = 1'b1;
    tick();

    // T6: single 16-bit channel, back-to-back period, hand-driven handshake
    push_frame(1'b1, 1, 16'hFFFF, 16'h0000, 16'h0000);
    en1 = 1'b1;
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!trmt1 && n < 50) begin
        tick();
        n++;
      end
      chk_eq("t6_trmt", 32'(trmt1), 32'd1);
      chk_eq("t6_sb_has_entry", 32'(exp_q1.size() > 0), 32'd1);
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        chk_eq("t6_byte", 32'(tx_data1), 32'(e));
      end
      if (b == 0) en1 = 1'b0;
      tick();
      tick();
      tx_done1 = 1'b1;
      tick();
      tx_done1 = 1'b0;
    end
    chk_eq("t6_busy_end", 32'(busy1), 32'd0);
    chk_eq("t6_overrun_b2b", 32'(overrun1), 32'd1);
    repeat (20) tick();
    chk_eq("t6_no_relaunch", 32'(trmt1 | busy1), 32'd0);

    // T1: nominal 3-channel frame
    resp_on = 1'b1;
    base = trmt_cnt;
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 1, 6000, "t1_launch");
    en = 1'b0;
    wait_cnt(base + 2, 40, "t1_sync1");
    chk_eq("t1_byte_gap", 32'(gap), 32'd12);
    wait_cnt(base + 9, 200, "t1_cksum");
    repeat (9) tick();
    chk_eq("t1_busy_before_done", 32'(busy), 32'd1);
    tick();
    chk_eq("t1_busy_after_done", 32'(busy), 32'd0);
    chk_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // T2: channel data changes mid-frame, snapshot still sent
    base = trmt_cnt;
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 1, 6000, "t2_launch");
    en = 1'b0;
    wait_cnt(base + 3, 60, "t2_third");
    ch_data = 36'd0;
    wait_cnt(base + 9, 200, "t2_cksum");
    wait_idle(40, "t2_idle");
    chk_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);
    ch_data = {12'h7FF, 12'h123, 12'hABC};

    // T3: period shorter than a frame -> overrun, relaunch only from IDLE
    period = PW'(20);
    base = trmt_cnt;
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 1, 40, "t3_launch");
    wait_cnt(base + 10, 300, "t3_second_launch");
    en = 1'b0;
    chk_eq("t3_relaunch_gap", 32'(gap >= 12 && gap <= 31), 32'd1);
    wait_idle(200, "t3_idle");
    chk_eq("t3_overrun_set", 32'(overrun), 32'd1);
    chk_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (50) tick();
    chk_eq("t3_no_third", 32'(trmt_cnt), 32'(base + 18));
    chk_eq("t3_overrun_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk_eq("t3_overrun_clr", 32'(overrun), 32'd0);

    // T4: en low keeps the line silent; dropping en mid-frame still completes it
    base = trmt_cnt;
    repeat (70) tick();
    chk_eq("t4_en_low_silent", 32'(trmt_cnt), 32'(base));
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 2, 60, "t4_sync1");
    en = 1'b0;
    wait_cnt(base + 9, 200, "t4_cksum");
    wait_idle(40, "t4_idle");
    repeat (60) tick();
    chk_eq("t4_silence_after", 32'(trmt_cnt), 32'(base + 9));
    chk_eq("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // T5: level tx_done advances once; reset mid-frame abandons it
    resp_on = 1'b0;
    tx_done_man = 1'b0;
    base = trmt_cnt;
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 1, 40, "t5_launch");
    en = 1'b0;
    repeat (3) tick();
    tx_done_man = 1'b1;
    repeat (30) tick();
    chk_eq("t5_level_one_step", 32'(trmt_cnt), 32'(base + 2));
    tx_done_man = 1'b0;
    repeat (2) tick();
    tx_done_man = 1'b1;
    tick();
    tx_done_man = 1'b0;
    repeat (4) tick();
    chk_eq("t5_pulse_step", 32'(trmt_cnt), 32'(base + 3));
    rst_n = 1'b0;
    #1;
    chk_eq("t5_rst_trmt", 32'(trmt), 32'd0);
    chk_eq("t5_rst_busy", 32'(busy), 32'd0);
    chk_eq("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk_eq("t5_rst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    resp_on = 1'b1;
    base = trmt_cnt;
    push_frame(1'b0, 3, 16'h0ABC, 16'h0123, 16'h07FF);
    en = 1'b1;
    wait_cnt(base + 1, 40, "t5_relaunch");
    en = 1'b0;
    wait_cnt(base + 9, 200, "t5_cksum");
    wait_idle(40, "t5_idle");
    chk_eq("t5_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
